riscv_wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the pipeline writeback stage and a long-latency result unit (multi-cycle MUL/DIV or CSR path) using a valid/ready handshake.
- Pipeline W results always take priority. Long-latency results queue in a small FIFO and drain into idle write slots.
- A scoreboard of pending destination registers drives the decode-stage hazard stall.
- A starvation counter asks upstream for a bubble when the queue cannot drain.

---
 rtl/riscv_wb_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_riscv_wb_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_port_arbiter.sv
// riscv_wb_port_arbiter
// Shares the register-file write port between the pipeline W stage and a
// long-latency result unit. W always wins; long-latency results wait in a
// small FIFO and drain into idle write slots. A pending-destination
// scoreboard drives the decode hazard stall, and a starvation counter
// requests an upstream bubble when queued results cannot drain.
//
// Optional feature macro: WB_LL_BYPASS_EN
//   defined   : with the queue empty and the W slot idle, an accepted
//               long-latency result is written in the same cycle.
//   undefined : every long-latency result goes through the queue.

`ifndef XLEN
`define XLEN 32
`endif

module riscv_wb_port_arbiter #(
  parameter int LL_FIFO_DEPTH = 2,
  parameter int STARVE_MAX    = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_ctrl_reg_wr_enW,
  input  logic [4:0]        i_regfile_rd_addrW,
  input  logic [`XLEN-1:0]  i_regfile_rd_dataW,
  input  logic              i_ll_valid,
  output logic              o_ll_ready,
  input  logic [4:0]        i_ll_rd_addr,
  input  logic [`XLEN-1:0]  i_ll_rd_data,
  input  logic              i_issue_en,
  input  logic [4:0]        i_issue_rd_addr,
  input  logic [4:0]        i_rs1_addr,
  input  logic [4:0]        i_rs2_addr,
  input  logic [4:0]        i_rd_addr,
  output logic              o_stall_hazard,
  output logic              o_pipe_stall,
  output logic              o_rf_wr_en,
  output logic [4:0]        o_rf_wr_addr,
  output logic [`XLEN-1:0]  o_rf_wr_data
);

  localparam int PTR_W = (LL_FIFO_DEPTH > 1) ? $clog2(LL_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]        q_addr [LL_FIFO_DEPTH];
  logic [`XLEN-1:0]  q_data [LL_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  q_count;
  logic [3:0]        starve_cnt;
  logic [31:0]       pending;
  logic [31:0]       pending_nxt;

  logic              q_empty;
  logic              q_full;
  logic              pipe_busy;
  logic              q_pop;
  logic              q_push;
  logic              ll_bypass;
  logic [4:0]        head_addr;
  logic [`XLEN-1:0]  head_data;

  assign q_empty   = (q_count == '0);
  assign q_full    = (q_count == CNT_W'(LL_FIFO_DEPTH));
  assign head_addr = q_addr[rd_ptr];
  assign head_data = q_data[rd_ptr];
  assign pipe_busy = i_ctrl_reg_wr_enW && (i_regfile_rd_addrW != 5'd0);

  // Ready comes from registered occupancy only, so a same-cycle pop never
  // opens a slot for the producer.
  assign o_ll_ready = !q_full;
  assign q_push     = i_ll_valid && !q_full && !ll_bypass;

  // Write-port mux: W first, then queue head, then (optionally) bypass.
  always_comb begin
    o_rf_wr_en   = 1'b0;
    o_rf_wr_addr = 5'd0;
    o_rf_wr_data = '0;
    q_pop        = 1'b0;
    ll_bypass    = 1'b0;
    if (pipe_busy) begin
      o_rf_wr_en   = 1'b1;
      o_rf_wr_addr = i_regfile_rd_addrW;
      o_rf_wr_data = i_regfile_rd_dataW;
    end else if (!q_empty) begin
      q_pop = 1'b1;
      if (head_addr != 5'd0) begin
        o_rf_wr_en   = 1'b1;
        o_rf_wr_addr = head_addr;
        o_rf_wr_data = head_data;
      end
    end
`ifdef WB_LL_BYPASS_EN
    else if (i_ll_valid) begin
      ll_bypass = 1'b1;
      if (i_ll_rd_addr != 5'd0) begin
        o_rf_wr_en   = 1'b1;
        o_rf_wr_addr = i_ll_rd_addr;
        o_rf_wr_data = i_ll_rd_data;
      end
    end
`endif
  end

  // Queue storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (q_push) begin
      q_addr[wr_ptr] <= i_ll_rd_addr;
      q_data[wr_ptr] <= i_ll_rd_data;
    end
  end

  // Queue pointers and occupancy; depth is a power of two so pointers wrap.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (q_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (q_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (q_push && !q_pop)      q_count <= q_count + CNT_W'(1);
      else if (q_pop && !q_push) q_count <= q_count - CNT_W'(1);
    end
  end

  // Scoreboard next state: drain clears first so a same-cycle issue wins.
  always_comb begin
    pending_nxt = pending;
    if (q_pop)     pending_nxt[head_addr]    = 1'b0;
    if (ll_bypass) pending_nxt[i_ll_rd_addr] = 1'b0;
    if (i_issue_en && (i_issue_rd_addr != 5'd0))
      pending_nxt[i_issue_rd_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) pending <= '0;
    else         pending <= pending_nxt;
  end

  assign o_stall_hazard = pending[i_rs1_addr] | pending[i_rs2_addr] | pending[i_rd_addr];

  // Starvation counter: counts undrained cycles while results are queued.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      starve_cnt <= 4'd0;
    end else if (q_empty || q_pop) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != 4'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign o_pipe_stall = (starve_cnt == 4'(STARVE_MAX));

endmodule

// File: tb/tb_riscv_wb_port_arbiter.sv
// Bench for riscv_wb_port_arbiter: a queue/array reference model checked
// every cycle, plus hand-computed literal expectations on directed vectors.

`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic              i_clk = 1'b0;
  logic              i_rstn;
  logic              i_ctrl_reg_wr_enW;
  logic [4:0]        i_regfile_rd_addrW;
  logic [`XLEN-1:0]  i_regfile_rd_dataW;
  logic              i_ll_valid;
  logic              o_ll_ready;
  logic [4:0]        i_ll_rd_addr;
  logic [`XLEN-1:0]  i_ll_rd_data;
  logic              i_issue_en;
  logic [4:0]        i_issue_rd_addr;
  logic [4:0]        i_rs1_addr;
  logic [4:0]        i_rs2_addr;
  logic [4:0]        i_rd_addr;
  logic              o_stall_hazard;
  logic              o_pipe_stall;
  logic              o_rf_wr_en;
  logic [4:0]        o_rf_wr_addr;
  logic [`XLEN-1:0]  o_rf_wr_data;

  riscv_wb_port_arbiter #(.LL_FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .i_clk              (i_clk),
    .i_rstn             (i_rstn),
    .i_ctrl_reg_wr_enW  (i_ctrl_reg_wr_enW),
    .i_regfile_rd_addrW (i_regfile_rd_addrW),
    .i_regfile_rd_dataW (i_regfile_rd_dataW),
    .i_ll_valid         (i_ll_valid),
    .o_ll_ready         (o_ll_ready),
    .i_ll_rd_addr       (i_ll_rd_addr),
    .i_ll_rd_data       (i_ll_rd_data),
    .i_issue_en         (i_issue_en),
    .i_issue_rd_addr    (i_issue_rd_addr),
    .i_rs1_addr         (i_rs1_addr),
    .i_rs2_addr         (i_rs2_addr),
    .i_rd_addr          (i_rd_addr),
    .o_stall_hazard     (o_stall_hazard),
    .o_pipe_stall       (o_pipe_stall),
    .o_rf_wr_en         (o_rf_wr_en),
    .o_rf_wr_addr       (o_rf_wr_addr),
    .o_rf_wr_data       (o_rf_wr_data)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [4:0]       rd;
    logic [`XLEN-1:0] data;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] pend = '0;
  int          starve = 0;

  logic             m_busy, m_pop, m_byp, m_acc, e_en;
  logic [4:0]       e_addr;
  logic [`XLEN-1:0] e_data;

  // Per-cycle compare against the model, then advance the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      if (!i_rstn) begin
        mq.delete();
        pend   = '0;
        starve = 0;
        check("rst_ll_ready",   32'(o_ll_ready),     32'd1);
        check("rst_pipe_stall", 32'(o_pipe_stall),   32'd0);
        check("rst_hazard",     32'(o_stall_hazard), 32'd0);
        check("rst_wr_en",      32'(o_rf_wr_en),     32'd0);
      end else begin
        m_busy = i_ctrl_reg_wr_enW && (i_regfile_rd_addrW != 5'd0);
        e_en = 1'b0; e_addr = 5'd0; e_data = '0; m_pop = 1'b0; m_byp = 1'b0;
        if (m_busy) begin
          e_en = 1'b1; e_addr = i_regfile_rd_addrW; e_data = i_regfile_rd_dataW;
        end else if (mq.size() > 0) begin
          m_pop = 1'b1;
          if (mq[0].rd != 5'd0) begin
            e_en = 1'b1; e_addr = mq[0].rd; e_data = mq[0].data;
          end
        end
`ifdef WB_LL_BYPASS_EN
        else if (i_ll_valid) begin
          m_byp = 1'b1;
          if (i_ll_rd_addr != 5'd0) begin
            e_en = 1'b1; e_addr = i_ll_rd_addr; e_data = i_ll_rd_data;
          end
        end
`endif
        check("m_wr_en",      32'(o_rf_wr_en),   32'(e_en));
        check("m_wr_addr",    32'(o_rf_wr_addr), 32'(e_addr));
        check("m_wr_data",    32'(o_rf_wr_data), 32'(e_data));
        check("m_ll_ready",   32'(o_ll_ready),   32'(mq.size() < DEPTH));
        check("m_hazard",     32'(o_stall_hazard),
              32'(pend[i_rs1_addr] | pend[i_rs2_addr] | pend[i_rd_addr]));
        check("m_pipe_stall", 32'(o_pipe_stall), 32'(starve == SMAX));

        m_acc = i_ll_valid && (mq.size() < DEPTH) && !m_byp;
        if (mq.size() == 0 || m_pop) starve = 0;
        else if (starve < SMAX)      starve++;
        if (m_pop) begin
          pend[mq[0].rd] = 1'b0;
          void'(mq.pop_front());
        end
        if (m_byp) pend[i_ll_rd_addr] = 1'b0;
        if (m_acc) mq.push_back('{rd: i_ll_rd_addr, data: i_ll_rd_data});
        if (i_issue_en && i_issue_rd_addr != 5'd0) pend[i_issue_rd_addr] = 1'b1;
        pend[0] = 1'b0;
      end
    end
  end

  task automatic idle_in();
    i_ctrl_reg_wr_enW  = 1'b0;
    i_regfile_rd_addrW = 5'd0;
    i_regfile_rd_dataW = '0;
    i_ll_valid         = 1'b0;
    i_ll_rd_addr       = 5'd0;
    i_ll_rd_data       = '0;
    i_issue_en         = 1'b0;
    i_issue_rd_addr    = 5'd0;
    i_rs1_addr         = 5'd0;
    i_rs2_addr         = 5'd0;
    i_rd_addr          = 5'd0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    idle_in();
  endtask

  task automatic w_wr(input logic [4:0] a, input logic [`XLEN-1:0] d);
    i_ctrl_reg_wr_enW  = 1'b1;
    i_regfile_rd_addrW = a;
    i_regfile_rd_dataW = d;
  endtask

  task automatic ll(input logic [4:0] a, input logic [`XLEN-1:0] d);
    i_ll_valid   = 1'b1;
    i_ll_rd_addr = a;
    i_ll_rd_data = d;
  endtask

  task automatic issue(input logic [4:0] a);
    i_issue_en      = 1'b1;
    i_issue_rd_addr = a;
  endtask

  initial begin
    idle_in();
    i_rstn = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    #2;
    check("idle_ll_ready", 32'(o_ll_ready), 32'd1);
    check("idle_wr_en",    32'(o_rf_wr_en), 32'd0);
    check("idle_pstall",   32'(o_pipe_stall), 32'd0);
    check("idle_hazard",   32'(o_stall_hazard), 32'd0);

    // Pipeline-only writes
    tick(); w_wr(5'd5, 32'hDEAD_BEEF); #2;
    check("w5_en",   32'(o_rf_wr_en),   32'd1);
    check("w5_addr", 32'(o_rf_wr_addr), 32'd5);
    check("w5_data", 32'(o_rf_wr_data), 32'hDEAD_BEEF);
    tick(); w_wr(5'd0, 32'h1); #2;
    check("w0_en", 32'(o_rf_wr_en), 32'd0);

    // Issue x7, then its long-latency result with W idle
    tick(); issue(5'd7);
    tick(); i_rs1_addr = 5'd7; ll(5'd7, 32'h1234); #2;
    check("x7_haz_hs", 32'(o_stall_hazard), 32'd1);
`ifdef WB_LL_BYPASS_EN
    check("x7_byp_en",   32'(o_rf_wr_en),   32'd1);
    check("x7_byp_data", 32'(o_rf_wr_data), 32'h1234);
    tick(); i_rs1_addr = 5'd7; #2;
    check("x7_haz_after", 32'(o_stall_hazard), 32'd0);
`else
    check("x7_hs_en", 32'(o_rf_wr_en), 32'd0);
    tick(); i_rs1_addr = 5'd7; #2;
    check("x7_wr_en",   32'(o_rf_wr_en),   32'd1);
    check("x7_wr_addr", 32'(o_rf_wr_addr), 32'd7);
    check("x7_wr_data", 32'(o_rf_wr_data), 32'h1234);
    check("x7_haz_wr",  32'(o_stall_hazard), 32'd1);
`endif
    tick(); i_rs1_addr = 5'd7; #2;
    check("x7_haz_done", 32'(o_stall_hazard), 32'd0);
    check("x7_idle_en",  32'(o_rf_wr_en), 32'd0);

    // Fill the queue while W is busy every cycle
    tick(); issue(5'd9);  w_wr(5'd1, 32'h111);
    tick(); issue(5'd11); w_wr(5'd1, 32'h112); ll(5'd9, 32'h90);
    tick(); w_wr(5'd1, 32'h113); ll(5'd11, 32'hB0); #2;
    check("fill_ready1", 32'(o_ll_ready), 32'd1);
    tick(); w_wr(5'd1, 32'h114); ll(5'd12, 32'hC0); #2;
    check("full_ready",  32'(o_ll_ready),   32'd0);
    check("full_pstall", 32'(o_pipe_stall), 32'd0);
    tick(); w_wr(5'd2, 32'h115);
    tick(); w_wr(5'd2, 32'h116); #2;
    check("pstall_3", 32'(o_pipe_stall), 32'd0);
    tick(); w_wr(5'd2, 32'h117); #2;
    check("pstall_4",    32'(o_pipe_stall), 32'd1);
    check("pstall_w_en", 32'(o_rf_wr_addr), 32'd2);
    // W idle: x9 drains while x9 is issued again
    tick(); issue(5'd9); i_rs2_addr = 5'd9; #2;
    check("drain9_en",     32'(o_rf_wr_en),   32'd1);
    check("drain9_addr",   32'(o_rf_wr_addr), 32'd9);
    check("drain9_data",   32'(o_rf_wr_data), 32'h90);
    check("drain9_pstall", 32'(o_pipe_stall), 32'd1);
    tick(); i_rs2_addr = 5'd9; #2;
    check("drain11_addr", 32'(o_rf_wr_addr), 32'd11);
    check("drain11_data", 32'(o_rf_wr_data), 32'hB0);
    check("drain_pstall", 32'(o_pipe_stall), 32'd0);
    check("haz9_kept",    32'(o_stall_hazard), 32'd1);
    tick(); i_rs2_addr = 5'd9; #2;
    check("haz9_kept2", 32'(o_stall_hazard), 32'd1);
    check("empty_en",   32'(o_rf_wr_en), 32'd0);

    // Asynchronous reset with two entries queued
    tick(); issue(5'd12); w_wr(5'd3, 32'h1); ll(5'd12, 32'hC0);
    tick(); w_wr(5'd3, 32'h2); ll(5'd13, 32'hD0);
    tick(); w_wr(5'd3, 32'h3); i_rs1_addr = 5'd9; #2;
    check("pre_rst_ready", 32'(o_ll_ready), 32'd0);
    i_ctrl_reg_wr_enW = 1'b0;
    i_rstn = 1'b0;
    #1;
    check("arst_ready",  32'(o_ll_ready),     32'd1);
    check("arst_wr_en",  32'(o_rf_wr_en),     32'd0);
    check("arst_hazard", 32'(o_stall_hazard), 32'd0);
    tick();
    tick(); i_rstn = 1'b1; #2;
    check("post_rst_en", 32'(o_rf_wr_en), 32'd0);

    // Queued entry to x0 pops silently
    tick(); w_wr(5'd4, 32'h44); ll(5'd0, 32'hEE);
    tick(); #2;
    check("x0_pop_en", 32'(o_rf_wr_en), 32'd0);
    tick(); #2;
    check("x0_after_en", 32'(o_rf_wr_en), 32'd0);

`ifdef WB_LL_BYPASS_EN
    tick(); issue(5'd3);
    tick(); ll(5'd3, 32'h55); i_rs1_addr = 5'd3; #2;
    check("byp_en",   32'(o_rf_wr_en),   32'd1);
    check("byp_addr", 32'(o_rf_wr_addr), 32'd3);
    check("byp_data", 32'(o_rf_wr_data), 32'h55);
    tick(); i_rs1_addr = 5'd3; #2;
    check("byp_haz",   32'(o_stall_hazard), 32'd0);
    check("byp_empty", 32'(o_rf_wr_en),     32'd0);
`endif

    // Mixed directed pattern, checked by the model only
    for (int i = 0; i < 48; i++) begin
      tick();
      if (i % 3 == 0) w_wr(5'(i % 32), 32'(i * 257));
      if (i % 2 == 0) ll(5'((i * 7) % 32), 32'(32'h1000 + i));
      if (i % 5 == 0) issue(5'((i * 3) % 32));
      i_rs1_addr = 5'(i % 32);
      i_rs2_addr = 5'((i + 5) % 32);
      i_rd_addr  = 5'((i * 11) % 32);
    end
    repeat (6) tick();
    #6;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
